// File: rtl/handshake_fifo_buffer.sv
// Valid/ready FIFO buffer with registered handshake outputs and no input-to-output bypass.
// The head word is kept in an output register that is reloaded from the next-state view of the storage.
module handshake_fifo_buffer #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] ins,
    input  logic                  ins_valid,
    output logic                  ins_ready,
    output logic [DATA_WIDTH-1:0] outs,
    output logic                  outs_valid,
    input  logic                  outs_ready
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    localparam logic [PTR_W-1:0] PTR_ZERO = PTR_W'(0);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [DATA_WIDTH-1:0] mem_r [0:DEPTH-1];
    logic [PTR_W-1:0]      wr_ptr_r;
    logic [PTR_W-1:0]      rd_ptr_r;
    logic [CNT_W-1:0]      count_r;
    logic                  ins_ready_r;
    logic                  outs_valid_r;
    logic [DATA_WIDTH-1:0] outs_r;

    logic                  push_s;
    logic                  pop_s;
    logic [PTR_W-1:0]      wr_next_s;
    logic [PTR_W-1:0]      rd_next_s;
    logic [CNT_W-1:0]      count_next_s;
    logic [DATA_WIDTH-1:0] head_next_s;

    assign push_s     = ins_valid & ins_ready_r;
    assign pop_s      = outs_valid_r & outs_ready;
    assign ins_ready  = ins_ready_r;
    assign outs_valid = outs_valid_r;
    assign outs       = outs_r;

    // Next write pointer, wrapping at the last slot
    always_comb begin
        wr_next_s = wr_ptr_r;
        if (push_s) begin
            wr_next_s = (wr_ptr_r == PTR_LAST) ? PTR_ZERO : (wr_ptr_r + PTR_ONE);
        end else begin
            wr_next_s = wr_ptr_r;
        end
    end

    // Next read pointer, wrapping at the last slot
    always_comb begin
        rd_next_s = rd_ptr_r;
        if (pop_s) begin
            rd_next_s = (rd_ptr_r == PTR_LAST) ? PTR_ZERO : (rd_ptr_r + PTR_ONE);
        end else begin
            rd_next_s = rd_ptr_r;
        end
    end

    // Occupancy update; simultaneous push and pop leaves it unchanged
    always_comb begin
        count_next_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_next_s = count_r + CNT_ONE;
            2'b01:   count_next_s = count_r - CNT_ONE;
            default: count_next_s = count_r;
        endcase
    end

    // New head: the word being written this edge if it lands in the next read slot
    always_comb begin
        head_next_s = mem_r[rd_next_s];
        if (push_s && (wr_ptr_r == rd_next_s)) begin
            head_next_s = ins;
        end else begin
            head_next_s = mem_r[rd_next_s];
        end
    end

    // Storage, pointers, occupancy and registered handshake outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            wr_ptr_r     <= PTR_ZERO;
            rd_ptr_r     <= PTR_ZERO;
            count_r      <= CNT_ZERO;
            ins_ready_r  <= 1'b1;
            outs_valid_r <= 1'b0;
            outs_r       <= '0;
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= ins;
            end
            wr_ptr_r     <= wr_next_s;
            rd_ptr_r     <= rd_next_s;
            count_r      <= count_next_s;
            ins_ready_r  <= (count_next_s != CNT_FULL);
            outs_valid_r <= (count_next_s != CNT_ZERO);
            outs_r       <= head_next_s;
        end
    end

endmodule

// File: tb/tb_handshake_fifo_buffer.sv
// Scoreboard bench: accepted input words are queued, and a negedge monitor checks every output handshake.
module tb_handshake_fifo_buffer;

    logic        clk;
    logic        rst;
    logic [10:0] a_ins, a_outs, b_ins, b_outs;
    logic        a_ivld, a_irdy, a_ovld, a_ordy;
    logic        b_ivld, b_irdy, b_ovld, b_ordy;

    logic [10:0] a_q[$];
    logic [10:0] b_q[$];
    logic        a_hold, b_hold;
    logic [10:0] a_hold_val, b_hold_val;
    int          a_pops, b_pops;
    int          mon_pass, mon_total;
    int          dir_pass, dir_total;

    handshake_fifo_buffer #(.DATA_WIDTH(11), .DEPTH(4)) dut_a (
        .clk(clk), .rst(rst), .ins(a_ins), .ins_valid(a_ivld), .ins_ready(a_irdy),
        .outs(a_outs), .outs_valid(a_ovld), .outs_ready(a_ordy));

    handshake_fifo_buffer #(.DATA_WIDTH(11), .DEPTH(3)) dut_b (
        .clk(clk), .rst(rst), .ins(b_ins), .ins_valid(b_ivld), .ins_ready(b_irdy),
        .outs(b_outs), .outs_valid(b_ovld), .outs_ready(b_ordy));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic mchk(input string name, input logic [31:0] act, input logic [31:0] exp);
        mon_total++;
        if (act === exp) mon_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Monitor: compare popped words against the queue, check stall stability, record accepted words
    always @(negedge clk or negedge rst) begin
        if (!rst) begin
            a_q.delete();
            b_q.delete();
            a_hold = 1'b0;
            b_hold = 1'b0;
        end else begin
            if (a_hold) mchk("a_stall_stable", {20'd0, a_ovld, a_outs}, {20'd0, 1'b1, a_hold_val});
            if (b_hold) mchk("b_stall_stable", {20'd0, b_ovld, b_outs}, {20'd0, 1'b1, b_hold_val});
            if (a_ovld && a_ordy) begin
                if (a_q.size() == 0) mchk("a_unexpected_out", 32'(a_outs), 32'hFFFF_FFFF);
                else mchk("a_out_data", 32'(a_outs), 32'(a_q.pop_front()));
                a_pops++;
            end
            if (b_ovld && b_ordy) begin
                if (b_q.size() == 0) mchk("b_unexpected_out", 32'(b_outs), 32'hFFFF_FFFF);
                else mchk("b_out_data", 32'(b_outs), 32'(b_q.pop_front()));
                b_pops++;
            end
            a_hold     = a_ovld && !a_ordy;
            a_hold_val = a_outs;
            b_hold     = b_ovld && !b_ordy;
            b_hold_val = b_outs;
            if (a_ivld && a_irdy) a_q.push_back(a_ins);
            if (b_ivld && b_irdy) b_q.push_back(b_ins);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        dir_total++;
        if (act === exp) dir_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int start_pops;
        int i;
        int cyc;
        logic took;
        logic [15:0] stall_pat;

        a_pops = 0; b_pops = 0;
        mon_pass = 0; mon_total = 0; dir_pass = 0; dir_total = 0;
        a_hold = 1'b0; b_hold = 1'b0; a_hold_val = '0; b_hold_val = '0;
        rst = 1'b0;
        a_ins = '0; a_ivld = 1'b0; a_ordy = 1'b0;
        b_ins = '0; b_ivld = 1'b0; b_ordy = 1'b0;
        stall_pat = 16'b1011_0010_0110_1001;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_ins_ready", 32'(a_irdy), 32'd1);
        chk("rst_outs_valid", 32'(a_ovld), 32'd0);
        chk("rst_outs", 32'(a_outs), 32'd0);
        rst = 1'b1;

        // Single word, 1-cycle latency, first edge after release accepts
        a_ins = 11'h218; a_ivld = 1'b1; a_ordy = 1'b1;
        tick();
        a_ivld = 1'b0;
        chk("lat_valid", 32'(a_ovld), 32'd1);
        chk("lat_data", 32'(a_outs), 32'h218);
        chk("lat_count1", 32'(dut_a.count_r), 32'd1);
        tick();
        chk("lat_count0", 32'(dut_a.count_r), 32'd0);
        chk("lat_empty", 32'(a_ovld), 32'd0);

        // Fill to full with 1..4, word 5 held off until a slot frees
        a_ordy = 1'b0;
        for (int v = 1; v <= 4; v++) begin
            a_ins = 11'(v); a_ivld = 1'b1;
            tick();
        end
        chk("full_ready", 32'(a_irdy), 32'd0);
        chk("full_count", 32'(dut_a.count_r), 32'd4);
        a_ins = 11'd5;
        tick();
        tick();
        chk("full_hold_ready", 32'(a_irdy), 32'd0);
        chk("full_hold_count", 32'(dut_a.count_r), 32'd4);
        a_ordy = 1'b1;
        tick();
        chk("full_ready_back", 32'(a_irdy), 32'd1);
        chk("full_pop_count", 32'(dut_a.count_r), 32'd3);
        tick();
        a_ivld = 1'b0;
        chk("full_pushpop_count", 32'(dut_a.count_r), 32'd3);
        repeat (3) tick();
        chk("full_drained", 32'(dut_a.count_r), 32'd0);
        chk("full_sb_empty", 32'(a_q.size()), 32'd0);
        chk("full_pops", 32'(a_pops), 32'd6);

        // Streaming at one word per cycle
        start_pops = a_pops;
        a_ordy = 1'b1;
        for (int k = 0; k < 20; k++) begin
            a_ins = 11'(k + 32); a_ivld = 1'b1;
            tick();
            chk("stream_count_le1", {31'd0, dut_a.count_r <= 3'd1}, 32'd1);
            chk("stream_valid", 32'(a_ovld), 32'd1);
        end
        a_ivld = 1'b0;
        tick();
        chk("stream_count0", 32'(dut_a.count_r), 32'd0);
        chk("stream_pops", 32'(a_pops - start_pops), 32'd20);
        chk("stream_sb_empty", 32'(a_q.size()), 32'd0);

        // Simultaneous push/pop at count=DEPTH-1 and count=1
        a_ordy = 1'b0;
        for (int v = 0; v < 3; v++) begin
            a_ins = 11'(16 + v); a_ivld = 1'b1;
            tick();
        end
        chk("pp3_before", 32'(dut_a.count_r), 32'd3);
        a_ins = 11'h013; a_ordy = 1'b1;
        tick();
        chk("pp3_after", 32'(dut_a.count_r), 32'd3);
        a_ivld = 1'b0;
        repeat (2) tick();
        chk("pp1_before", 32'(dut_a.count_r), 32'd1);
        a_ins = 11'h014; a_ivld = 1'b1;
        tick();
        chk("pp1_after", 32'(dut_a.count_r), 32'd1);
        chk("pp1_head", 32'(a_outs), 32'h014);
        a_ivld = 1'b0;
        tick();
        chk("pp_drained", 32'(dut_a.count_r), 32'd0);
        chk("pp_sb_empty", 32'(a_q.size()), 32'd0);

        // Asynchronous reset with 3 words stored
        a_ordy = 1'b0;
        for (int v = 0; v < 3; v++) begin
            a_ins = 11'(11'h100 + v); a_ivld = 1'b1;
            tick();
        end
        a_ivld = 1'b0;
        chk("ar_count3", 32'(dut_a.count_r), 32'd3);
        #2 rst = 1'b0;
        #1;
        chk("ar_outs_valid", 32'(a_ovld), 32'd0);
        chk("ar_ins_ready", 32'(a_irdy), 32'd1);
        chk("ar_outs", 32'(a_outs), 32'd0);
        chk("ar_count", 32'(dut_a.count_r), 32'd0);
        rst = 1'b1;
        a_ins = 11'h7FF; a_ivld = 1'b1; a_ordy = 1'b1;
        tick();
        a_ivld = 1'b0;
        chk("ar_first_valid", 32'(a_ovld), 32'd1);
        chk("ar_first_data", 32'(a_outs), 32'h7FF);
        tick();
        chk("ar_sb_empty", 32'(a_q.size()), 32'd0);

        // DEPTH=3 instance: 9 words through stall patterns and pointer wrap
        start_pops = b_pops;
        i = 0;
        cyc = 0;
        b_ivld = 1'b1;
        while (i < 9 && cyc < 200) begin
            b_ins = 11'(11'h0CD * i + 3);
            b_ordy = stall_pat[cyc % 16];
            took = b_irdy;
            tick();
            if (took) i++;
            cyc++;
        end
        b_ivld = 1'b0;
        chk("wrap_all_pushed", 32'(i), 32'd9);
        b_ordy = 1'b1;
        cyc = 0;
        while (b_ovld && cyc < 20) begin
            tick();
            cyc++;
        end
        chk("wrap_drained", 32'(b_ovld), 32'd0);
        chk("wrap_pops", 32'(b_pops - start_pops), 32'd9);
        chk("wrap_sb_empty", 32'(b_q.size()), 32'd0);

        #20;
        $display("%0d/%0d checks passed", mon_pass + dir_pass, mon_total + dir_total);
        $finish;
    end

endmodule
